// File: rtl/arbitro_paridade_if.sv
// Bundle of the requester, generator and result handshakes of arbitro_paridade.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface arbitro_paridade_if;
    // Requester A
    logic       req_a;
    logic [3:0] dado_a;
    logic       ultimo_a;
    logic       ack_a;
    // Requester B
    logic       req_b;
    logic [3:0] dado_b;
    logic       ultimo_b;
    logic       ack_b;
    // Shared combinational parity generator
    logic [3:0] ger_dado;
    logic       ger_paridade;
    // Result port
    logic       saida_valida;
    logic       saida_pronto;
    logic       saida_paridade;
    logic       saida_origem;
    logic [3:0] saida_nibbles;

    modport slave (
        input  req_a, dado_a, ultimo_a,
        input  req_b, dado_b, ultimo_b,
        input  ger_paridade,
        input  saida_pronto,
        output ack_a, ack_b,
        output ger_dado,
        output saida_valida, saida_paridade, saida_origem, saida_nibbles
    );

    modport master (
        output req_a, dado_a, ultimo_a,
        output req_b, dado_b, ultimo_b,
        output ger_paridade,
        output saida_pronto,
        input  ack_a, ack_b,
        input  ger_dado,
        input  saida_valida, saida_paridade, saida_origem, saida_nibbles
    );
endinterface

// File: rtl/arbitro_paridade.sv
// Round-robin arbiter sharing one external 4-bit even-parity generator between
// requesters A and B. Each packet's nibble parities are XOR-accumulated and the
// packet parity, origin and saturating nibble count are offered on a
// ready/valid result port.
module arbitro_paridade (
    input  logic         clock,
    input  logic         reset,
    arbitro_paridade_if.slave bus
);

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        APLICA    = 2'd1,
        COLETA    = 2'd2,
        RESULTADO = 2'd3
    } estado_t;

    estado_t    estado_reg, estado_next;
    logic       vencedor_reg, vencedor_next;       // 0 = A, 1 = B
    logic       prioridade_reg, prioridade_next;   // preferred side on a tie
    logic       acumulador_reg, acumulador_next;
    logic [3:0] contador_reg, contador_next;

    // Result shadow registers: loaded when the packet closes so the result port
    // keeps its last values while the next packet is being accumulated.
    logic       saida_paridade_reg, saida_paridade_next;
    logic       saida_origem_reg, saida_origem_next;
    logic [3:0] saida_nibbles_reg, saida_nibbles_next;

    // Signals of whichever requester currently owns the packet lock.
    logic       req_vencedor;
    logic       ultimo_vencedor;
    logic [3:0] dado_vencedor;

    assign req_vencedor    = vencedor_reg ? bus.req_b    : bus.req_a;
    assign ultimo_vencedor = vencedor_reg ? bus.ultimo_b : bus.ultimo_a;
    assign dado_vencedor   = vencedor_reg ? bus.dado_b   : bus.dado_a;

    // State and datapath registers; asynchronous reset drops any partial packet.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_reg         <= OCIOSO;
            vencedor_reg       <= 1'b0;
            prioridade_reg     <= 1'b0;
            acumulador_reg     <= 1'b0;
            contador_reg       <= 4'd0;
            saida_paridade_reg <= 1'b0;
            saida_origem_reg   <= 1'b0;
            saida_nibbles_reg  <= 4'd0;
        end else begin
            estado_reg         <= estado_next;
            vencedor_reg       <= vencedor_next;
            prioridade_reg     <= prioridade_next;
            acumulador_reg     <= acumulador_next;
            contador_reg       <= contador_next;
            saida_paridade_reg <= saida_paridade_next;
            saida_origem_reg   <= saida_origem_next;
            saida_nibbles_reg  <= saida_nibbles_next;
        end
    end

    // Next-state logic: grant, per-nibble accumulation, result hand-off.
    always_comb begin
        estado_next         = estado_reg;
        vencedor_next       = vencedor_reg;
        prioridade_next     = prioridade_reg;
        acumulador_next     = acumulador_reg;
        contador_next       = contador_reg;
        saida_paridade_next = saida_paridade_reg;
        saida_origem_next   = saida_origem_reg;
        saida_nibbles_next  = saida_nibbles_reg;

        case (estado_reg)
            OCIOSO: begin
                if (bus.req_a || bus.req_b) begin
                    // A lone requester wins outright; a tie goes to prioridade.
                    if (bus.req_a && bus.req_b) begin
                        vencedor_next = prioridade_reg;
                    end else begin
                        vencedor_next = bus.req_b;
                    end
                    acumulador_next = 1'b0;
                    contador_next   = 4'd0;
                    estado_next     = APLICA;
                end
            end

            APLICA: begin
                acumulador_next = acumulador_reg ^ bus.ger_paridade;
                if (contador_reg != 4'hF) begin
                    contador_next = contador_reg + 4'd1;
                end
                if (ultimo_vencedor) begin
                    saida_paridade_next = acumulador_reg ^ bus.ger_paridade;
                    saida_origem_next   = vencedor_reg;
                    saida_nibbles_next  = (contador_reg != 4'hF) ? contador_reg + 4'd1
                                                                 : contador_reg;
                    estado_next         = RESULTADO;
                end else begin
                    estado_next = COLETA;
                end
            end

            COLETA: begin
                // The lock has no timeout; the other requester waits.
                if (req_vencedor) begin
                    estado_next = APLICA;
                end
            end

            RESULTADO: begin
                if (bus.saida_pronto) begin
                    prioridade_next = ~vencedor_reg;
                    estado_next     = OCIOSO;
                end
            end

            default: begin
                estado_next = OCIOSO;
            end
        endcase
    end

    // Moore outputs decoded from the registered state.
    assign bus.ger_dado       = (estado_reg == APLICA) ? dado_vencedor : 4'd0;
    assign bus.ack_a          = (estado_reg == APLICA) && !vencedor_reg;
    assign bus.ack_b          = (estado_reg == APLICA) &&  vencedor_reg;
    assign bus.saida_valida   = (estado_reg == RESULTADO);
    assign bus.saida_paridade = saida_paridade_reg;
    assign bus.saida_origem   = saida_origem_reg;
    assign bus.saida_nibbles  = saida_nibbles_reg;

endmodule
